// File: rtl/sw_result_collector_pkg.sv
// sw_result_collector_pkg: shared widths, FSM states and record layout for the SmithWaterman result collector
package sw_result_collector_pkg;
  localparam int CALC_BIT = 12;
  localparam int MAX_T_NUM_BIT = 4;
  localparam int T_IDX_BIT = MAX_T_NUM_BIT + 1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2, ST_DONE = 2'd3} state_t;
  localparam int REC_T_CNT_LSB = 0;
  localparam int REC_MAX_LSB = REC_T_CNT_LSB + T_IDX_BIT;
  localparam int REC_MIDX_LSB = REC_MAX_LSB + CALC_BIT;
  localparam int REC_Q_LSB = REC_MIDX_LSB + MAX_T_NUM_BIT;
  `define SW_REC_W(q_bits) (sw_result_collector_pkg::REC_Q_LSB + (q_bits))
  function automatic logic [T_IDX_BIT-1:0] sat_inc(input logic [T_IDX_BIT-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sw_result_fifo.sv
// sw_result_fifo: synchronous FIFO (push/pop in, empty/drop out); pop on empty ignored, push on full accepted only with a pop
module sw_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, do_pop, do_push;
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop = push & full & ~do_pop;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/sw_result_collector.sv
// sw_result_collector: folds the SmithWaterman result stream into per-query records {q_idx, match_idx, max_result, t_count}
// buffered for a valid/ready host; reports done_o, sticky ovf_o and, with SW_RESULT_CHECK_EN, a sticky checker err_o.
module sw_result_collector
  import sw_result_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int Q_IDX_BIT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              valid_i,
  input  logic [CALC_BIT-1:0]               result_i,
  input  logic                              change_q_i,
  input  logic [MAX_T_NUM_BIT-1:0]          match_idx_i,
  input  logic [CALC_BIT-1:0]               max_result_i,
  input  logic                              busy_i,
  output logic                              rd_valid_o,
  input  logic                              rd_ready_i,
  output logic [`SW_REC_W(Q_IDX_BIT)-1:0]   rd_data_o,
  output logic                              done_o,
  output logic                              ovf_o,
  output logic                              err_o
);
  localparam int REC_W = `SW_REC_W(Q_IDX_BIT);
  state_t state, state_nxt;
  logic [T_IDX_BIT-1:0] t_idx, t_cnt;
  logic [Q_IDX_BIT-1:0] q_idx;
  logic start, beat, last, empty, drop;
  assign start = (state == ST_IDLE || state == ST_DONE) && busy_i;
  assign beat = (state == ST_RUN || state == ST_FLUSH) && valid_i;
  assign last = beat && change_q_i;
  assign t_cnt = sat_inc(t_idx);
  assign rd_valid_o = ~empty;
  assign done_o = state == ST_DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: state_nxt = busy_i ? ST_RUN : state;
      ST_RUN: state_nxt = busy_i ? ST_RUN : ST_FLUSH;
      default: state_nxt = empty ? ST_DONE : ST_FLUSH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t_idx <= '0;
      q_idx <= '0;
    end else if (start) begin
      t_idx <= '0;
      q_idx <= '0;
    end else if (last) begin
      t_idx <= '0;
      q_idx <= q_idx + 1'b1;
    end else if (beat) begin
      t_idx <= t_cnt;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_o <= 1'b0;
    else if (drop) ovf_o <= 1'b1;
  sw_result_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (last),
    .pop   (rd_ready_i),
    .din   ({q_idx, match_idx_i, max_result_i, t_cnt}),
    .dout  (rd_data_o),
    .empty (empty),
    .drop  (drop)
  );
`ifdef SW_RESULT_CHECK_EN
  logic [CALC_BIT-1:0] ck_max, nx_max;
  logic [MAX_T_NUM_BIT-1:0] ck_idx, nx_idx;
  logic take;
  // t_idx==0 marks the first beat of a query; later beats replace only on a strictly larger result
  assign take = (t_idx == '0) || (result_i > ck_max);
  assign nx_max = take ? result_i : ck_max;
  assign nx_idx = take ? t_idx[MAX_T_NUM_BIT-1:0] : ck_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ck_max <= '0;
      ck_idx <= '0;
      err_o <= 1'b0;
    end else if (start) begin
      ck_max <= '0;
      ck_idx <= '0;
    end else if (last) begin
      ck_max <= '0;
      ck_idx <= '0;
      err_o <= err_o | (nx_max != max_result_i) | (nx_idx != match_idx_i);
    end else if (beat) begin
      ck_max <= nx_max;
      ck_idx <= nx_idx;
    end
`else
  logic unused_result;
  assign unused_result = ^result_i;
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sw_result_collector.sv
module tb_sw_result_collector;
  import sw_result_collector_pkg::*;
  localparam int DEPTH = 4;
  localparam int QB = 8;
  localparam int RW = QB + MAX_T_NUM_BIT + CALC_BIT + MAX_T_NUM_BIT + 1;
  localparam int TMAX = (1 << (MAX_T_NUM_BIT + 1)) - 1;
  typedef logic [RW-1:0] rec_t;
  logic clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, change_q_i = 1'b0, busy_i = 1'b0, rd_ready_i = 1'b0;
  logic [CALC_BIT-1:0] result_i = '0, max_result_i = '0;
  logic [MAX_T_NUM_BIT-1:0] match_idx_i = '0;
  logic rd_valid_o, done_o, ovf_o, err_o;
  rec_t rd_data_o;
  int total = 0, bad = 0;
  rec_t mfifo[$], got[$], exp_q[$];
  int mq = 0, mt = 0;
  bit mact = 0;

  sw_result_collector #(.DEPTH(DEPTH), .Q_IDX_BIT(QB)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .result_i(result_i), .change_q_i(change_q_i),
    .match_idx_i(match_idx_i), .max_result_i(max_result_i), .busy_i(busy_i), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .done_o(done_o), .ovf_o(ovf_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(input int q, input int mi, input int mr, input int t);
    return {8'(q), 4'(mi), 12'(mr), 5'(t)};
  endfunction

  // Reference: a job counts targets per query; each finished query becomes one record
  // appended to a queue of at most DEPTH entries (same-cycle pop frees a slot first).
  task automatic cycle(input logic b, input logic v, input logic cq, input logic [CALC_BIT-1:0] res,
                       input logic [MAX_T_NUM_BIT-1:0] mi, input logic [CALC_BIT-1:0] mr, input logic rdy);
    bit pop;
    busy_i = b; valid_i = v; change_q_i = cq; result_i = res; match_idx_i = mi; max_result_i = mr; rd_ready_i = rdy;
    @(posedge clk);
    pop = rdy && mfifo.size() > 0;
    if (pop) void'(mfifo.pop_front());
    if (b && !mact) begin
      mact = 1; mq = 0; mt = 0;
    end else if (mact && v && cq) begin
      if (mfifo.size() < DEPTH) mfifo.push_back(mk(mq, mi, mr, (mt + 1 > TMAX) ? TMAX : mt + 1));
      mq = (mq + 1) % 256; mt = 0;
    end else if (mact && v) begin
      mt = (mt + 1 > TMAX) ? TMAX : mt + 1;
    end
    #1;
  endtask

  task automatic send(input int vals[$], input int midx_force, input bit rdy_last);
    int best = 0, bi = 0, n = vals.size();
    for (int i = 0; i < n; i++) if (i == 0 || vals[i] > best) begin best = vals[i]; bi = i; end
    for (int i = 0; i < n; i++)
      cycle(1, 1, i == n - 1, 12'(vals[i]), (i == n - 1) ? 4'(midx_force >= 0 ? midx_force : bi) : 4'd0,
            (i == n - 1) ? 12'(best) : 12'd0, rdy_last && i == n - 1);
  endtask

  function automatic void rand_vals(output int vals[$], input int n);
    vals.delete();
    for (int i = 0; i < n; i++) vals.push_back(int'($urandom_range(4095, 0)));
  endfunction

  task automatic pop_all(input logic b);
    got.delete();
    for (int k = 0; k < 20 && rd_valid_o; k++) begin
      got.push_back(rd_data_o);
      cycle(b, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic hard_reset();
    rst_n = 0; busy_i = 0; valid_i = 0; change_q_i = 0; rd_ready_i = 0;
    mfifo.delete(); mact = 0; mq = 0; mt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total += 4;
    if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid_o); end
    if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    if (ovf_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL reset_flags: got ovf=%b err=%b want 0 0", ovf_o, err_o); end
    if (rd_data_o !== '0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data_o); end
    rst_n = 1;
  endtask

  task automatic test_basic();
    int v[$] = '{5, 12, 7};
    cycle(1, 0, 0, 0, 0, 0, 0);
    send(v, 1, 0);
    total += 3;
    if (rd_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", rd_valid_o); end
    if (rd_data_o !== mk(0, 1, 12, 3)) begin bad++; $display("FAIL basic_record: got %h want %h", rd_data_o, mk(0, 1, 12, 3)); end
    cycle(0, 0, 0, 0, 0, 0, 1);
    if (done_o !== 1'b0 || rd_valid_o !== 1'b0) begin bad++; $display("FAIL basic_after_pop: got done=%b valid=%b want 0 0", done_o, rd_valid_o); end
    cycle(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (done_o !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", done_o); end
    mact = 0;
  endtask

  task automatic test_multi();
    int v[$];
    cycle(1, 0, 0, 0, 0, 0, 0);
    rand_vals(v, 4); send(v, -1, 0);
    rand_vals(v, 4); send(v, -1, 0);
    exp_q = mfifo;
    pop_all(1);
    total++;
    if (got.size() != 2) begin bad++; $display("FAIL multi_count: got %0d want 2", got.size()); end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      total++;
      if (got[i] !== exp_q[i] || got[i][RW-1 -: QB] !== 8'(i) || got[i][4:0] !== 5'd4) begin
        bad++; $display("FAIL multi_rec%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (done_o !== 1'b0) begin bad++; $display("FAIL flush_empty_early: got %b want 0", done_o); end
    cycle(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (done_o !== 1'b1) begin bad++; $display("FAIL flush_empty_done: got %b want 1", done_o); end
    mact = 0;
  endtask

  task automatic test_overflow();
    int v[$];
    int qs[4] = '{1, 2, 3, 5};
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int q = 0; q < 5; q++) begin
      rand_vals(v, int'($urandom_range(6, 1))); send(v, -1, 0);
      total++;
      if (q == 3 && ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", ovf_o); end
      if (q != 3 && rd_data_o !== mfifo[0]) begin bad++; $display("FAIL ovf_head_q%0d: got %h want %h", q, rd_data_o, mfifo[0]); end
    end
    total++;
    if (ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf_o); end
    rand_vals(v, int'($urandom_range(6, 1))); send(v, -1, 1);
    exp_q = mfifo;
    pop_all(1);
    total++;
    if (got.size() != 4) begin bad++; $display("FAIL ovf_held: got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] !== exp_q[i] || got[i][RW-1 -: QB] !== 8'(qs[i])) begin
        bad++; $display("FAIL ovf_rec%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (done_o !== 1'b1 || ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_done: got done=%b ovf=%b want 1 1", done_o, ovf_o); end
    mact = 0;
  endtask

  task automatic test_restart_and_saturate();
    int v[$];
    cycle(1, 0, 0, 0, 0, 0, 0);
    rand_vals(v, int'($urandom_range(5, 1))); send(v, -1, 0);
    total += 2;
    if (ovf_o !== 1'b1) begin bad++; $display("FAIL restart_ovf: got %b want 1", ovf_o); end
    if (rd_data_o !== mfifo[0] || rd_data_o[RW-1 -: QB] !== 8'd0) begin bad++; $display("FAIL restart_q0: got %h want %h", rd_data_o, mfifo[0]); end
    pop_all(1);
    rand_vals(v, 35); send(v, -1, 0);
    total++;
    if (rd_data_o !== mfifo[0] || rd_data_o[4:0] !== 5'd31 || rd_data_o[RW-1 -: QB] !== 8'd1) begin
      bad++; $display("FAIL saturate: got %h want %h", rd_data_o, mfifo[0]);
    end
    pop_all(0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (done_o !== 1'b1) begin bad++; $display("FAIL saturate_done: got %b want 1", done_o); end
    mact = 0;
  endtask

  task automatic test_reset_mid();
    int v[$];
    cycle(1, 0, 0, 0, 0, 0, 0);
    rand_vals(v, 3); send(v, -1, 0);
    rand_vals(v, 2); send(v, -1, 0);
    #2 rst_n = 0;
    #1;
    total++;
    if (rd_valid_o !== 1'b0 || done_o !== 1'b0 || ovf_o !== 1'b0 || rd_data_o !== '0) begin
      bad++; $display("FAIL midreset: got valid=%b done=%b ovf=%b data=%h want all 0", rd_valid_o, done_o, ovf_o, rd_data_o);
    end
    hard_reset();
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (done_o !== 1'b0) begin bad++; $display("FAIL midreset_idle: got done=%b want 0", done_o); end
    cycle(1, 0, 0, 0, 0, 0, 0);
    rand_vals(v, 3); send(v, -1, 0);
    total++;
    if (rd_data_o !== mfifo[0] || rd_data_o[RW-1 -: QB] !== 8'd0) begin bad++; $display("FAIL midreset_q0: got %h want %h", rd_data_o, mfifo[0]); end
    pop_all(1);
  endtask

  task automatic test_checker();
`ifdef SW_RESULT_CHECK_EN
    int v[$] = '{9, 9, 3};
    hard_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    send(v, 1, 0);
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL checker_tie_idx1: got %b want 1", err_o); end
    hard_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    send(v, 0, 0);
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL checker_tie_idx0: got %b want 0", err_o); end
`else
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL err_tied: got %b want 0", err_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_overflow();
    test_restart_and_saturate();
    test_reset_mid();
    test_checker();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
